// File: rtl/joypad.sv
// joypad: scans two NES-style controllers and presents their buttons as
// parallel bytes. Build option: JOYPAD_DEBOUNCE_EN.
// Ports: clk, reset (sync, active-high); pad0/pad1 serial data (active-low);
//   padlatch/padclk drive the pads; input0/input1 button bytes (1 = pressed,
//   bit 7 = A .. bit 0 = Right); scandone pulses once per completed scan.
module joypad #(
  parameter int DIV  = 4,
  parameter int POLL = 357954
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad0,
  input  logic       pad1,
  output logic       padlatch,
  output logic       padclk,
  output logic [7:0] input0,
  output logic [7:0] input1,
  output logic       scandone
);

  localparam int PW = $clog2(2 * DIV);
  localparam logic [PW-1:0] PH_HALF  = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_LATCH = PW'(2 * DIV - 1);
  localparam logic [23:0]   POLL_TC  = 24'(POLL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [23:0]   poll_q, poll_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    sync0_q, sync0_d;
  logic [1:0]    sync1_q, sync1_d;
  logic [6:0]    raw0_q, raw0_d;
  logic [6:0]    raw1_q, raw1_d;
  logic [7:0]    in0_q, in0_d;
  logic [7:0]    in1_q, in1_d;
`ifdef JOYPAD_DEBOUNCE_EN
  logic [7:0]    prev0_q, prev0_d;
  logic [7:0]    prev1_q, prev1_d;
`endif

  logic       tc;
  logic       samp;
  logic       fin;
  logic [7:0] byte0;
  logic [7:0] byte1;

  assign tc = (poll_q == POLL_TC);

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      poll_q  <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      sync0_q <= '1;
      sync1_q <= '1;
      raw0_q  <= '0;
      raw1_q  <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
`ifdef JOYPAD_DEBOUNCE_EN
      prev0_q <= '0;
      prev1_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      raw0_q  <= raw0_d;
      raw1_q  <= raw1_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
`ifdef JOYPAD_DEBOUNCE_EN
      prev0_q <= prev0_d;
      prev1_q <= prev1_d;
`endif
    end
  end

  // next state and counters
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    poll_d  = tc ? '0 : poll_q + 24'd1;
    unique case (state_q)
      S_IDLE: begin
        if (tc) begin
          state_d = S_LATCH;
          ph_d    = '0;
        end
      end
      S_LATCH: begin
        if (ph_q == PH_LATCH) begin
          state_d = S_LOW;
          ph_d    = '0;
          bit_d   = '0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_LOW: begin
        if (ph_q == PH_HALF) begin
          ph_d    = '0;
          state_d = (bit_q == 3'd7) ? S_DONE : S_HIGH;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_HIGH: begin
        if (ph_q == PH_HALF) begin
          ph_d    = '0;
          bit_d   = bit_q + 3'd1;
          state_d = S_LOW;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // sampling and result capture; the eighth bit goes straight into the
  // output so the full byte appears in the DONE cycle
  always_comb begin
    sync0_d = {sync0_q[0], pad0};
    sync1_d = {sync1_q[0], pad1};
    samp    = (state_q == S_LOW) && (ph_q == PH_HALF);
    fin     = samp && (bit_q == 3'd7);
    byte0   = {raw0_q, ~sync0_q[1]};
    byte1   = {raw1_q, ~sync1_q[1]};
    raw0_d  = (samp && !fin) ? byte0[6:0] : raw0_q;
    raw1_d  = (samp && !fin) ? byte1[6:0] : raw1_q;
`ifdef JOYPAD_DEBOUNCE_EN
    prev0_d = fin ? byte0 : prev0_q;
    prev1_d = fin ? byte1 : prev1_q;
    in0_d   = (fin && byte0 == prev0_q) ? byte0 : in0_q;
    in1_d   = (fin && byte1 == prev1_q) ? byte1 : in1_q;
`else
    in0_d   = fin ? byte0 : in0_q;
    in1_d   = fin ? byte1 : in1_q;
`endif
  end

  // outputs
  always_comb begin
    padlatch = (state_q == S_LATCH);
    padclk   = (state_q == S_HIGH);
    scandone = (state_q == S_DONE);
    input0   = in0_q;
    input1   = in1_q;
  end

endmodule

// File: doc/joypad.md
# joypad

Scans two physical NES-style controllers over a shared latch/clock pair and two serial data lines, and presents the button states as parallel bytes. Sits directly upstream of the I/O register block: its `input0`/`input1` outputs feed that block's controller shift registers, which load them while the CPU holds the strobe bit. Scans run autonomously at a fixed poll rate; outputs change only at scan completion, never mid-scan.

## Interface
- `DIV`, 4: clk cycles per pad-clock half period; must be at least 4.
- `POLL`, 357954: clk cycles between scan starts; must be greater than 17*`DIV`+2 and less than 2^24.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `pad0` in 1: controller 0 serial data, active-low (0 = pressed), asynchronous.
- `pad1` in 1: controller 1 serial data, active-low, asynchronous.
- `padlatch` out 1: latch to both controllers, active-high.
- `padclk` out 1: shift clock to both controllers; idle 0.
- `input0` out 8: controller 0 buttons; 1 = pressed; bit 7 = A, then B, Select, Start, Up, Down, Left, bit 0 = Right.
- `input1` out 8: controller 1 buttons, same layout.
- `scandone` out 1: one-cycle pulse when a scan completes.

## Operation
- `pad0` and `pad1` pass through 2-flop synchronizers; all sampling uses the synchronized values.
- A 24-bit poll counter runs 0..`POLL`-1 and wraps. At terminal count in IDLE, a scan starts. A terminal count outside IDLE is dropped; the counter keeps running.
- A phase counter counts 0..`DIV`-1 within each half period. A bit counter runs 0..7.
- States:
  - IDLE: `padlatch`=0, `padclk`=0.
  - LATCH: `padlatch`=1 for 2*`DIV` cycles, then go to LOW with bit=0.
  - LOW: `padclk`=0 for `DIV` cycles. On the last cycle, sample the inverted synchronized data into raw bit (7-bit) for each pad. If bit=7, go to DONE; otherwise go to HIGH.
  - HIGH: `padclk`=1 for `DIV` cycles, increment bit, return to LOW.
  - DONE: one cycle. Update `input0`/`input1` from raw (see Configuration), pulse `scandone`, go to IDLE.
- `input0` and `input1` update in one cycle, so no partially scanned value is ever visible.

## Timing
- Reset values: `padlatch`=0, `padclk`=0, `input0`=0, `input1`=0, `scandone`=0. State is IDLE and all counters are 0.
- First scan: `padlatch` rises `POLL` cycles after the first cycle with `reset` deasserted.
- Scan length: LATCH 2*`DIV` + 8 LOW phases * `DIV` + 7 HIGH phases * `DIV` = 17*`DIV` cycles, then DONE.
- The updated `input0`/`input1` are visible and `scandone`=1 in the cycle after the final LOW cycle; `scandone` is 0 the next cycle.
- Pad data input to output latency: 2 synchronizer cycles + sampling point. Data must be stable from the rising edge of `padclk` until the end of the following LOW phase.
- Reset asserted mid-scan: immediate return to IDLE. All outputs take reset values on the next edge, counters clear, and raw bits (and the previous-scan register, if built) clear to 0.
- After the last bit there is no trailing `padclk` pulse; `padclk` stays 0 until the next scan.

## Configuration
- `JOYPAD_DEBOUNCE_EN` defined:
  - Keep the previous scan's raw byte per pad.
  - A pad's output updates in DONE only if the current raw byte equals the previous raw byte; otherwise the output holds.
  - The previous-scan register loads the current raw byte in every DONE.
  - `scandone` pulses every scan regardless of whether outputs changed.
- Undefined: outputs load the raw bytes in every DONE; no previous-scan register exists.

## Test plan
- Reset, then `DIV`=4, `POLL`=100, both pads idle high:
  - `padlatch` high for 8 cycles starting 100 cycles after reset release.
  - 7 `padclk` pulses of 4 cycles high each.
  - `input0`=`input1`=8'h00; `scandone` pulses once at cycle 100+68.
- Controller model for pad0 presents A=pressed, Start=pressed (serial 0,1,1,0,1,1,1,1); pad1 all pressed:
  - Without the macro: `input0`=8'h90 and `input1`=8'hFF after the first scan.
- Same stimulus with `JOYPAD_DEBOUNCE_EN`:
  - Outputs stay 8'h00 after scan 1.
  - Outputs become 8'h90/8'hFF after scan 2.
  - Toggling pad0 to a different value for one scan leaves `input0` at 8'h90.
- Assert `reset` during the HIGH phase of bit 3 with `input0`=8'h90:
  - Next cycle: `padclk`=0, `input0`=8'h00, no `scandone`.
  - Next scan starts 100 cycles after release.
- Data changes mid-scan: pad0 switches from all-released to all-pressed after bit 3 is sampled:
  - `input0`=8'h0F. The value holds until DONE; intermediate cycles still show the previous value.
- `POLL`=60 with `DIV`=4 (a scan longer than one poll period):
  - The terminal count during the scan is dropped; no restart mid-scan.
  - The next scan begins at the following terminal count in IDLE.
